// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder family.
//   state_e        : controller states (IDLE / RUN / DONE)
//   cnt_width()    : step-counter width, max(1, clog2(steps))
//   params_ok()    : legality of a (W, K) pair, used for elaboration checks
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned steps);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(steps)) w++;
    return w;
  endfunction

  function automatic bit params_ok(input int unsigned w, input int unsigned k);
    return (w >= 1) && (k >= 1) && (k <= w) && ((w % k) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder cell, purely combinational.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: a + b + cin over W bits, K bits per clock, using a
// K-cell ripple chain iterated W/K times. Valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   a, b, cin           : operands and carry-in, latched on acceptance
//   out_valid/out_ready : result handshake (held in DONE until out_ready)
//   sum, cout, overflow : registered result, unsigned carry, signed overflow
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int unsigned STEPS = (K == 0) ? 1 : (W / K);
  localparam int unsigned CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (!params_ok(W, K)) begin : g_bad_params
    $error("serial_adder: illegal parameters W=%0d K=%0d", W, K);
  end

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [K-1:0]   sum_bits;
  logic           chain_ci_top;
  logic           chain_co;
  logic [W+K-1:0] acc_shift;

  // Each stage owns its carry wires so the ripple is not a self-loop on one
  // vector; stage i reads the carry-out of stage i-1 directly.
  for (genvar gi = 0; gi < K; gi++) begin : g_cell
    logic ci, co, s;
    if (gi == 0) begin : g_first
      assign ci = carry_q;
    end else begin : g_next
      assign ci = g_cell[gi-1].co;
    end
    fa_cell u_fa (
      .a  (a_q[gi]),
      .b  (b_q[gi]),
      .ci (ci),
      .s  (s),
      .co (co)
    );
    assign sum_bits[gi] = s;
  end

  assign chain_ci_top = g_cell[K-1].ci;
  assign chain_co     = g_cell[K-1].co;

  // New sum bits enter at the top; dropping the low K bits of the
  // concatenation is a right shift that also works when K == W.
  assign acc_shift = {sum_bits, acc_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> K;
        b_d     = b_q >> K;
        acc_d   = acc_shift[W+K-1:K];
        carry_d = chain_co;
        if (cnt_q == LAST) begin
          // Counter holds on the last step so it never wraps.
          sum_d   = acc_shift[W+K-1:K];
          cout_d  = chain_co;
          ovf_d   = chain_ci_top ^ chain_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder in three configurations:
//   sel 0: W=8  K=1,  sel 1: W=16 K=4,  sel 2: W=8 K=8
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv0, ir0, ov0, or0, cin0, co0, of0;
  logic [7:0] a0, b0, s0;
  logic        iv1, ir1, ov1, or1, cin1, co1, of1;
  logic [15:0] a1, b1, s1;
  logic       iv2, ir2, ov2, or2, cin2, co2, of2;
  logic [7:0] a2, b2, s2;

  serial_adder #(.W(8), .K(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .cin(cin0), .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0), .overflow(of0));
  serial_adder #(.W(16), .K(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .overflow(of1));
  serial_adder #(.W(8), .K(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .cin(cin2), .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .overflow(of2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ir(input int sel);
    case (sel) 0: return ir0; 1: return ir1; default: return ir2; endcase
  endfunction
  function automatic logic f_ov(input int sel);
    case (sel) 0: return ov0; 1: return ov1; default: return ov2; endcase
  endfunction
  function automatic logic [15:0] f_sum(input int sel);
    case (sel) 0: return {8'h00, s0}; 1: return s1; default: return {8'h00, s2}; endcase
  endfunction
  function automatic logic f_co(input int sel);
    case (sel) 0: return co0; 1: return co1; default: return co2; endcase
  endfunction
  function automatic logic f_of(input int sel);
    case (sel) 0: return of0; 1: return of1; default: return of2; endcase
  endfunction

  task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic v);
    case (sel)
      0: begin a0 = a[7:0]; b0 = b[7:0]; cin0 = c; iv0 = v; end
      1: begin a1 = a;      b1 = b;      cin1 = c; iv1 = v; end
      default: begin a2 = a[7:0]; b2 = b[7:0]; cin2 = c; iv2 = v; end
    endcase
  endtask

  task automatic set_ready(input int sel, input logic r);
    case (sel) 0: or0 = r; 1: or1 = r; default: or2 = r; endcase
  endtask

  // One full transaction: accept, count latency, check result, hold DONE for
  // 'gap' cycles of backpressure, then release.
  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input int gap, input bit noise, input string tag);
    logic [16:0] full;
    logic [15:0] exp_s;
    logic        exp_c, exp_o, ma, mb, ms;
    logic [31:0] rnd;
    int          steps, lat, t;
    steps = (sel == 0) ? 8 : (sel == 1) ? 4 : 1;
    full  = {1'b0, a} + {1'b0, b} + {16'h0, c};
    if (sel == 1) begin
      exp_s = full[15:0]; exp_c = full[16];
      ma = a[15]; mb = b[15]; ms = exp_s[15];
    end else begin
      exp_s = {8'h00, full[7:0]}; exp_c = full[8];
      ma = a[7]; mb = b[7]; ms = exp_s[7];
    end
    exp_o = (ma == mb) && (ms != ma);

    @(negedge clk);
    t = 0;
    while (!f_ir(sel) && t < 50) begin @(negedge clk); t++; end
    check({tag, " in_ready idle"}, {31'h0, f_ir(sel)}, 32'h1);
    set_ready(sel, 1'b0);
    drive(sel, a, b, c, 1'b1);
    @(posedge clk);
    #1 drive(sel, ~a, ~b, ~c, 1'b0);
    lat = 0;
    do begin
      if (noise) begin
        rnd = $urandom;
        drive(sel, rnd[15:0], rnd[31:16], rnd[0], ~rnd[1]);
      end
      @(posedge clk);
      lat++;
      #1;
    end while (!f_ov(sel) && lat < 100);
    drive(sel, ~a, b, c, 1'b0);
    check({tag, " latency"}, lat, steps);
    check({tag, " sum"}, {16'h0, f_sum(sel)}, {16'h0, exp_s});
    check({tag, " cout"}, {31'h0, f_co(sel)}, {31'h0, exp_c});
    check({tag, " overflow"}, {31'h0, f_of(sel)}, {31'h0, exp_o});
    check({tag, " in_ready in DONE"}, {31'h0, f_ir(sel)}, 32'h0);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      check({tag, " bp out_valid"}, {31'h0, f_ov(sel)}, 32'h1);
      check({tag, " bp in_ready"}, {31'h0, f_ir(sel)}, 32'h0);
      check({tag, " bp sum"}, {16'h0, f_sum(sel)}, {16'h0, exp_s});
    end
    set_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_ready(sel, 1'b0);
    check({tag, " out_valid drop"}, {31'h0, f_ov(sel)}, 32'h0);
    check({tag, " back to idle"}, {31'h0, f_ir(sel)}, 32'h1);
    check({tag, " sum kept"}, {16'h0, f_sum(sel)}, {16'h0, exp_s});
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive(s, 16'h0, 16'h0, 1'b0, 1'b0);
      set_ready(s, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check("reset in_ready", {31'h0, f_ir(s)}, 32'h1);
      check("reset out_valid", {31'h0, f_ov(s)}, 32'h0);
      check("reset sum", {16'h0, f_sum(s)}, 32'h0);
      check("reset cout", {31'h0, f_co(s)}, 32'h0);
      check("reset overflow", {31'h0, f_of(s)}, 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;

    // W=8 K=1 directed
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0, "k1 ff+01");
    do_op(0, 16'h007F, 16'h0001, 1'b0, 5, 1'b0, "k1 7f+01");
    do_op(0, 16'h0000, 16'h0000, 1'b1, 1, 1'b0, "k1 0+0+1");

    // Reset three steps into an 8-step add
    @(negedge clk);
    drive(0, 16'h0055, 16'h000F, 1'b0, 1'b1);
    @(posedge clk);
    #1 drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid-run out_valid", {31'h0, ov0}, 32'h0);
    check("rst mid-run in_ready", {31'h0, ir0}, 32'h1);
    check("rst mid-run sum", {24'h0, s0}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    do_op(0, 16'h0012, 16'h0034, 1'b0, 0, 1'b0, "k1 after rst");
    do_op(0, 16'h00A5, 16'h005A, 1'b1, 2, 1'b1, "k1 noise");
    do_op(0, 16'h0080, 16'h0080, 1'b0, 0, 1'b1, "k1 noise2");

    // W=16 K=4 directed
    do_op(1, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "k4 ffff+1");
    do_op(1, 16'h7FFF, 16'h0001, 1'b0, 3, 1'b0, "k4 7fff+1");
    do_op(1, 16'h8000, 16'h8000, 1'b0, 0, 1'b0, "k4 8000+8000");
    do_op(1, 16'h1234, 16'h4321, 1'b1, 0, 1'b1, "k4 1234+4321+1");

    // W=8 K=8 directed
    do_op(2, 16'h0080, 16'h0080, 1'b0, 0, 1'b0, "k8 80+80");
    do_op(2, 16'h00FF, 16'h00FF, 1'b1, 2, 1'b0, "k8 ff+ff+1");
    do_op(2, 16'h0012, 16'h0034, 1'b0, 0, 1'b0, "k8 12+34");

    // Random operands with random backpressure gaps
    for (int n = 0; n < 100; n++) begin
      r = $urandom;
      do_op(1, r[15:0], r[31:16], r[5], int'($urandom_range(0, 3)), 1'b0, "k4 rnd");
      r = $urandom;
      do_op(2, {8'h00, r[7:0]}, {8'h00, r[15:8]}, r[16], int'($urandom_range(0, 3)), 1'b0, "k8 rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
